// File: rtl/fir_seq_counter.sv
// Terminal-count sequencer stepping FIR tap iterations per output sample.
// Optional tc_early look-ahead output: define FIR_SEQ_CNT_EARLY_EN.
module fir_seq_counter #(
    parameter int WIDTH        = 8,
    parameter bit WRAP_DEFAULT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             en,
    input  logic             abort,
    input  logic             mode_wrap,
    input  logic [WIDTH-1:0] num,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             flags,
    output logic             tc
`ifdef FIR_SEQ_CNT_EARLY_EN
    ,
    output logic             tc_early
`endif
);

    if (WIDTH < 2 || WIDTH > 32 || WRAP_DEFAULT > 1'b1) begin : g_param_check
        $error("fir_seq_counter: illegal parameter value");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] num_q;
    logic [WIDTH-1:0] num_n;
    logic             wrap_q;
    logic             wrap_n;
    logic [WIDTH-1:0] count_n;
    logic             flags_n;
    logic             tc_n;
    logic             busy_n;

    always_comb begin
        state_n = state;
        num_n   = num_q;
        wrap_n  = wrap_q;
        count_n = count;
        flags_n = flags;
        tc_n    = 1'b0;
        if (abort) begin
            state_n = IDLE;
            count_n = '0;
            flags_n = 1'b0;
        end else if (start) begin
            state_n = RUN;
            num_n   = num;
            wrap_n  = mode_wrap;
            count_n = '0;
            flags_n = 1'b0;
        end else if (state == RUN && en) begin
            // Compare before incrementing so all-ones never overflows.
            if (count == num_q) begin
                tc_n    = 1'b1;
                flags_n = 1'b1;
                if (wrap_q) begin
                    count_n = '0;
                end else begin
                    state_n = DONE;
                end
            end else begin
                count_n = count + WIDTH'(1);
            end
        end
        busy_n = (state_n == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            num_q  <= '0;
            wrap_q <= 1'b0;
            count  <= '0;
            busy   <= 1'b0;
            flags  <= 1'b0;
            tc     <= 1'b0;
        end else begin
            state  <= state_n;
            num_q  <= num_n;
            wrap_q <= wrap_n;
            count  <= count_n;
            busy   <= busy_n;
            flags  <= flags_n;
            tc     <= tc_n;
        end
    end

`ifdef FIR_SEQ_CNT_EARLY_EN
    // Built from next-state values so it lines up with the registered count.
    always_ff @(posedge clk) begin
        if (reset) begin
            tc_early <= 1'b0;
        end else begin
            tc_early <= (state_n == RUN) && (count_n == num_n);
        end
    end
`endif

endmodule

// File: tb/tb_fir_seq_counter.sv
// Scoreboarded directed bench for fir_seq_counter (WIDTH=8).
module tb_fir_seq_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       en = 1'b0;
    logic       abort = 1'b0;
    logic       mode_wrap = 1'b0;
    logic [7:0] num = '0;
    logic [7:0] count;
    logic       busy;
    logic       flags;
    logic       tc;
`ifdef FIR_SEQ_CNT_EARLY_EN
    logic       tc_early;
`endif

    fir_seq_counter #(.WIDTH(8), .WRAP_DEFAULT(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .en        (en),
        .abort     (abort),
        .mode_wrap (mode_wrap),
        .num       (num),
        .count     (count),
        .busy      (busy),
        .flags     (flags),
        .tc        (tc)
`ifdef FIR_SEQ_CNT_EARLY_EN
        ,
        .tc_early  (tc_early)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] count;
        logic       busy;
        logic       flags;
        logic       tc;
        logic       early;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: 0 idle, 1 run, 2 done.
    int         m_state = 0;
    logic [7:0] m_count = '0;
    logic [7:0] m_numq = '0;
    logic       m_wrap = 1'b0;
    logic       m_flags = 1'b0;
    logic       m_tc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t",
                   tag, obs, want, $time);
        end
    endtask

    task automatic step(input logic r, input logic a, input logic s,
                        input logic e, input logic w, input logic [7:0] n);
        exp_t x;
        exp_t got;
        @(negedge clk);
        reset = r;
        abort = a;
        start = s;
        en = e;
        mode_wrap = w;
        num = n;
        m_tc = 1'b0;
        if (r) begin
            m_state = 0; m_count = 0; m_numq = 0;
            m_wrap = 0;  m_flags = 0;
        end else if (a) begin
            m_state = 0; m_count = 0; m_flags = 0;
        end else if (s) begin
            m_state = 1; m_count = 0; m_flags = 0;
            m_numq = n;  m_wrap = w;
        end else if (m_state == 1 && e) begin
            if (m_count == m_numq) begin
                m_tc = 1'b1;
                m_flags = 1'b1;
                if (m_wrap) m_count = 0;
                else m_state = 2;
            end else begin
                m_count = m_count + 8'd1;
            end
        end
        x.count = m_count;
        x.busy = (m_state == 1);
        x.flags = m_flags;
        x.tc = m_tc;
        x.early = (m_state == 1) && (m_count == m_numq);
        q.push_back(x);
        @(posedge clk);
        #1;
        got = q.pop_front();
        chk("count", 32'(count), 32'(got.count));
        chk("busy", 32'(busy), 32'(got.busy));
        chk("flags", 32'(flags), 32'(got.flags));
        chk("tc", 32'(tc), 32'(got.tc));
`ifdef FIR_SEQ_CNT_EARLY_EN
        chk("tc_early", 32'(tc_early), 32'(got.early));
`endif
    endtask

    int tc_seen;

    initial begin
        // Reset state.
        step(1, 0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 1, 1, 8'h55);
        chk("rst_count", 32'(count), 32'd0);

        // One-shot num=3, en held high.
        step(0, 0, 1, 1, 0, 8'd3);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 8'($urandom));
        chk("oneshot_hold", 32'(count), 32'd3);
        chk("oneshot_done", 32'({busy, flags}), 32'b01);

        // num=5 with en toggling; num changes in RUN are ignored.
        step(0, 0, 1, 1, 0, 8'd5);
        tc_seen = 0;
        for (int i = 0; i < 14; i++) begin
            step(0, 0, 0, (i % 2) == 0, 1, 8'($urandom));
            if (tc) tc_seen++;
        end
        chk("toggle_tc_once", 32'(tc_seen), 32'd1);

        // Auto-reload num=2.
        step(0, 0, 1, 1, 1, 8'd2);
        tc_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 1, 0, 8'd9);
            if (tc) tc_seen++;
        end
        chk("wrap_tc_count", 32'(tc_seen), 32'd3);

        // num=0: terminal on first enabled edge.
        step(0, 0, 1, 1, 0, 8'd0);
        step(0, 0, 0, 1, 0, 8'd0);
        chk("num0_tc", 32'(tc), 32'd1);
        step(0, 0, 0, 1, 0, 8'd0);

        // num=all-ones: 256 enabled edges, no overflow.
        step(0, 0, 1, 1, 0, 8'hFF);
        for (int i = 0; i < 257; i++) step(0, 0, 0, 1, 0, 8'hFF);
        chk("ff_hold", 32'(count), 32'hFF);

        // Abort at count=4.
        step(0, 0, 1, 1, 0, 8'd9);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 8'd9);
        step(0, 1, 0, 1, 0, 8'd9);
        step(0, 0, 0, 1, 0, 8'd9);

        // Restart at count=2 with num=7.
        step(0, 0, 1, 1, 0, 8'd9);
        step(0, 0, 0, 1, 0, 8'd9);
        step(0, 0, 0, 1, 0, 8'd9);
        step(0, 0, 1, 1, 0, 8'd7);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0, 8'd1);

        // Start on the terminal edge suppresses tc.
        step(0, 0, 1, 1, 0, 8'd1);
        step(0, 0, 0, 1, 0, 8'd1);
        step(0, 0, 1, 1, 0, 8'd1);
        chk("restart_no_tc", 32'(tc), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 8'd1);

        // Reset during RUN.
        step(0, 0, 1, 1, 1, 8'd6);
        step(0, 0, 0, 1, 0, 8'd6);
        step(0, 0, 0, 1, 0, 8'd6);
        step(1, 0, 1, 1, 0, 8'd6);
        chk("rst_run", 32'({count, busy, flags, tc}), 32'd0);

        // Stall at count=3 (exercises tc_early when built).
        step(0, 0, 1, 1, 0, 8'd3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 8'd3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 8'd3);
        step(0, 0, 0, 1, 0, 8'd3);
        step(0, 0, 0, 1, 0, 8'd3);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
